onchip_mem_streamer: RTL and testbench
======================================

ONCHIP_MEM_STREAMER -- requirements
Module: onchip_mem_streamer

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, memory word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory and stream data width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, output buffer entries (power of 2, at least 2).
REQ-004 SHALL have port clk  in  1  sole clock, all logic rising-edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port start  in  1  command strobe, sampled only in IDLE.
REQ-007 SHALL have port base_addr  in  ADDR_W  first word address of the command.
REQ-008 SHALL have port length  in  ADDR_W+1  word count, 0..65536.
REQ-009 SHALL have port busy  out  1  high whenever the state is not IDLE.
REQ-010 SHALL have port done  out  1  one-cycle completion pulse.
REQ-011 SHALL have port mem_address  out  ADDR_W  word address to the on-chip RAM.
REQ-012 SHALL have port mem_chipselect  out  1  read issue strobe; mem_write tied 0, mem_byteenable tied all-ones.
REQ-013 SHALL have port mem_clken  out  1  RAM clock enable, constant 1.
REQ-014 SHALL have port mem_readdata  in  DATA_W  RAM data, valid one cycle after issue.
REQ-015 SHALL have ports out_data (out, DATA_W), out_valid (out, 1), out_ready (in, 1), out_last (out, 1): valid/ready stream.

Function
REQ-016 SHALL implement states IDLE, RUN, DRAIN; IDLE->RUN on start with length>0; RUN->DRAIN after last read issued; DRAIN->IDLE on final stream handshake.
REQ-017 SHALL, on start with length==0, stay IDLE, issue no reads, and pulse done the next cycle.
REQ-018 SHALL ignore start while busy, including the cycle of the final handshake.
REQ-019 SHALL issue one read per cycle in RUN only when in-flight reads plus FIFO occupancy < FIFO_DEPTH (credit rule); FIFO never overflows.
REQ-020 SHALL write mem_readdata into the FIFO exactly one cycle after each issue, regardless of out_ready.
REQ-021 SHALL increment mem_address per issue, wrapping 2^ADDR_W-1 -> 0.
REQ-022 SHALL present out_valid while FIFO non-empty; out_data and out_last stable until handshake.
REQ-023 SHALL assert out_last with the final word of the command only.
REQ-024 SHALL pulse done the cycle after the handshake carrying out_last.
REQ-025 SHALL sustain one word per cycle with out_ready held high after a two-cycle startup latency (start to first out_valid).
REQ-026 SHALL handle simultaneous FIFO write and read with occupancy unchanged.

Reset
REQ-027 SHALL, on reset_n low, asynchronously force IDLE, FIFO empty, credits zero, busy/done/out_valid/out_last/mem_chipselect 0, mem_address 0.
REQ-028 SHALL discard any command in progress on reset; a read returning after reset release is dropped.

Configuration
REQ-029 SHALL support macro ONCHIP_MEM_STREAMER_LOOP_EN: when defined, adds input loop (1) and stop (1); with loop high, after the last word the address reloads base_addr and reading restarts with no idle cycle, out_last still marks each pass end, done pulses only after the pass in which stop was seen.
REQ-030 SHALL, without the macro, have no loop/stop ports and always end after one pass.

Structure
REQ-031 SHALL place the state enum and default-width constants in shared package onchip_mem_pkg.
REQ-032 SHALL implement the buffer as sub-module stream_fifo (synchronous, FIFO_DEPTH entries, count output).

Verification
REQ-033 SHALL cover: base 0x0010, length 4, out_ready=1 -> words from 0x0010..0x0013 in order, out_last on 4th, done one cycle later.
REQ-034 SHALL cover: base 0xFFFE, length 4 -> addresses 0xFFFE,0xFFFF,0x0000,0x0001.
REQ-035 SHALL cover: length 16, out_ready toggled randomly -> 16 words, no loss, no duplicate, mem_chipselect never issued with full credits.
REQ-036 SHALL cover: length 0 -> no mem_chipselect, done pulse next cycle, busy stays 0.
REQ-037 SHALL cover: reset_n low mid-RUN of length 8 -> all outputs 0 immediately; new start after release streams cleanly.
REQ-038 SHALL cover (LOOP_EN): base 0x0100, length 2, loop=1, stop after 3rd word -> 4 words, out_last on 2nd and 4th, single done.

Source files
------------

// File: rtl/onchip_mem_pkg.sv
// Shared types and default sizes for the on-chip memory streamer.
package onchip_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam int DEF_ADDR_W     = 16;
   localparam int DEF_DATA_W     = 32;
   localparam int DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO with occupancy count; holds {last, data} words for the stream port.
module stream_fifo
   import onchip_mem_pkg::*;
#(
   parameter int WIDTH = DEF_DATA_W + 1,
   parameter int DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     i_wr,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_rd,
   output logic [WIDTH-1:0]         o_rdata,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             w_do_wr;
   logic             w_do_rd;

   assign w_do_wr = i_wr && (r_count != (PTR_W+1)'(DEPTH));
   assign w_do_rd = i_rd && (r_count != '0);

   always_ff @(posedge clk) begin
      if (w_do_wr) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   // A simultaneous push and pop leaves the occupancy unchanged.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_wr) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_do_rd) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_do_wr, w_do_rd})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_rdata = r_mem[r_rd_ptr];
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

endmodule

// File: rtl/onchip_mem_streamer.sv
// Streams a block of on-chip RAM words out of a valid/ready port with credit-based read issue.
// Optional repeat mode (loop/stop ports) is enabled by defining ONCHIP_MEM_STREAMER_LOOP_EN.
module onchip_mem_streamer
   import onchip_mem_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
`ifdef ONCHIP_MEM_STREAMER_LOOP_EN
   input  logic                loop,
   input  logic                stop,
`endif
   input  logic [ADDR_W-1:0]   base_addr,
   input  logic [ADDR_W:0]     length,
   output logic                busy,
   output logic                done,
   output logic [ADDR_W-1:0]   mem_address,
   output logic                mem_chipselect,
   output logic                mem_write,
   output logic [DATA_W/8-1:0] mem_byteenable,
   output logic                mem_clken,
   input  logic [DATA_W-1:0]   mem_readdata,
   output logic [DATA_W-1:0]   out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                out_last
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   state_t              r_state;
   state_t              w_next_state;
   logic [ADDR_W-1:0]   r_addr;
   logic [ADDR_W:0]     r_remain;
   logic                r_inflight;
   logic                r_inflight_last;
   logic                r_done;
   logic [CNT_W-1:0]    w_count;
   logic                w_empty;
   logic [DATA_W:0]     w_fifo_rdata;
   logic                w_credit_ok;
   logic                w_issue;
   logic                w_pass_end;
   logic                w_repeat;
   logic                w_handshake;
   logic                w_final_hs;
   logic                w_accept;
   logic [ADDR_W-1:0]   w_reload_addr;
   logic [ADDR_W:0]     w_reload_len;

   // A read may only issue if its word is guaranteed a FIFO slot on return.
   assign w_credit_ok = ({1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight}) < (CNT_W+1)'(FIFO_DEPTH);
   assign w_issue     = (r_state == ST_RUN) && w_credit_ok;
   assign w_pass_end  = w_issue && (r_remain == (ADDR_W+1)'(1));
   assign w_handshake = out_valid && out_ready;
   assign w_final_hs  = (r_state == ST_DRAIN) && w_handshake && !r_inflight &&
                        (w_count == CNT_W'(1));
   assign w_accept    = (r_state == ST_IDLE) && start;

`ifdef ONCHIP_MEM_STREAMER_LOOP_EN
   logic              r_stop;
   logic [ADDR_W-1:0] r_base;
   logic [ADDR_W:0]   r_len;

   // Stop is sticky so that the pass during which it was seen becomes the last one.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_stop <= 1'b0;
         r_base <= '0;
         r_len  <= '0;
      end else if (w_accept) begin
         r_stop <= 1'b0;
         r_base <= base_addr;
         r_len  <= length;
      end else if (busy && stop) begin
         r_stop <= 1'b1;
      end
   end

   assign w_repeat      = loop && !r_stop && !stop;
   assign w_reload_addr = r_base;
   assign w_reload_len  = r_len;
`else
   assign w_repeat      = 1'b0;
   assign w_reload_addr = '0;
   assign w_reload_len  = '0;
`endif

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:  if (start && (length != '0)) w_next_state = ST_RUN;
         ST_RUN:   if (w_pass_end && !w_repeat) w_next_state = ST_DRAIN;
         ST_DRAIN: if (w_final_hs) w_next_state = ST_IDLE;
         default:  w_next_state = ST_IDLE;
      endcase
   end

   // Reset clears the in-flight flag, so a read returning after release is never stored.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state         <= ST_IDLE;
         r_addr          <= '0;
         r_remain        <= '0;
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
         r_done          <= 1'b0;
      end else begin
         r_state         <= w_next_state;
         r_inflight      <= w_issue;
         r_inflight_last <= w_pass_end;
         r_done          <= (w_accept && (length == '0)) || w_final_hs;
         if (w_accept) begin
            r_addr   <= base_addr;
            r_remain <= length;
         end else if (w_issue) begin
            if (w_pass_end && w_repeat) begin
               r_addr   <= w_reload_addr;
               r_remain <= w_reload_len;
            end else begin
               r_addr   <= r_addr + ADDR_W'(1);
               r_remain <= r_remain - (ADDR_W+1)'(1);
            end
         end
      end
   end

   stream_fifo #(
      .WIDTH (DATA_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .i_wr    (r_inflight),
      .i_wdata ({r_inflight_last, mem_readdata}),
      .i_rd    (w_handshake),
      .o_rdata (w_fifo_rdata),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign busy           = (r_state != ST_IDLE);
   assign done           = r_done;
   assign mem_address    = r_addr;
   assign mem_chipselect = w_issue;
   assign mem_write      = 1'b0;
   assign mem_byteenable = '1;
   assign mem_clken      = 1'b1;
   assign out_valid      = !w_empty;
   assign out_data       = w_fifo_rdata[DATA_W-1:0];
   assign out_last       = !w_empty && w_fifo_rdata[DATA_W];

endmodule

// File: tb/tb_onchip_mem_streamer.sv
// Directed scoreboard bench for onchip_mem_streamer; the repeat-mode case runs when
// ONCHIP_MEM_STREAMER_LOOP_EN is defined.
module tb_onchip_mem_streamer;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 4;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic              last;
      logic              fin;
   } exp_t;

   logic                clk = 1'b0;
   logic                reset_n;
   logic                start;
   logic                loop;
   logic                stop;
   logic [ADDR_W-1:0]   base_addr;
   logic [ADDR_W:0]     length;
   logic                busy;
   logic                done;
   logic [ADDR_W-1:0]   mem_address;
   logic                mem_chipselect;
   logic                mem_write;
   logic [DATA_W/8-1:0] mem_byteenable;
   logic                mem_clken;
   logic [DATA_W-1:0]   mem_readdata;
   logic [DATA_W-1:0]   out_data;
   logic                out_valid;
   logic                out_ready;
   logic                out_last;

   exp_t              sbQ[$];
   logic [ADDR_W-1:0] addrQ[$];
   int                total = 0;
   int                bad = 0;
   int                csCount = 0;
   int                doneCount = 0;
   int                occ = 0;
   bit                tbInflight = 0;
   bit                hsSeen = 0;
   bit                csSeen = 0;
   bit                doneExpNext = 0;
   bit                zeroStart = 0;

   always #5 clk = ~clk;

   onchip_mem_streamer #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .start          (start),
`ifdef ONCHIP_MEM_STREAMER_LOOP_EN
      .loop           (loop),
      .stop           (stop),
`endif
      .base_addr      (base_addr),
      .length         (length),
      .busy           (busy),
      .done           (done),
      .mem_address    (mem_address),
      .mem_chipselect (mem_chipselect),
      .mem_write      (mem_write),
      .mem_byteenable (mem_byteenable),
      .mem_clken      (mem_clken),
      .mem_readdata   (mem_readdata),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_last       (out_last)
   );

   function automatic logic [DATA_W-1:0] memWord(input logic [ADDR_W-1:0] a);
      return {~a, a} ^ 32'h5A00_00C3;
   endfunction

   // Synchronous RAM model: data for an issued address appears the following cycle.
   always @(posedge clk) begin
      if (mem_chipselect) mem_readdata <= memWord(mem_address);
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Monitor: pops the scoreboard on each handshake, checks addresses, credits and done.
   always @(negedge clk) begin
      bit doneNow;
      exp_t e;
      if (reset_n) begin
         if (done) doneCount++;
         if (done || doneExpNext) checkOutput("done_pulse", 64'(done), 64'(doneExpNext));
         doneNow = start && zeroStart;
         if (out_valid && out_ready) begin
            checkOutput("sb_has_entry", 64'(sbQ.size() > 0), 64'd1);
            if (sbQ.size() > 0) begin
               e = sbQ.pop_front();
               checkOutput("out_data", 64'(out_data), 64'(e.data));
               checkOutput("out_last", 64'(out_last), 64'(e.last));
               doneNow = doneNow || (e.last && e.fin);
            end
         end
         doneExpNext = doneNow;
         if (mem_chipselect) begin
            csCount++;
            checkOutput("credit_ok", 64'((int'(tbInflight) + occ) < DEPTH), 64'd1);
            checkOutput("addr_q_has", 64'(addrQ.size() > 0), 64'd1);
            if (addrQ.size() > 0) checkOutput("mem_address", 64'(mem_address), 64'(addrQ.pop_front()));
         end
         hsSeen = out_valid && out_ready;
         csSeen = mem_chipselect;
      end
   end

   always @(posedge clk) begin
      if (reset_n) begin
         occ        = occ + int'(tbInflight) - int'(hsSeen);
         tbInflight = csSeen;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clearModel();
      sbQ.delete();
      addrQ.delete();
      occ = 0;
      tbInflight = 0;
      hsSeen = 0;
      csSeen = 0;
      doneExpNext = 0;
   endtask

   // Drives a one-cycle start and records what the command should produce.
   task automatic applyStimulus(input logic [ADDR_W-1:0] b, input int len, input int passes);
      logic [ADDR_W-1:0] a;
      exp_t e;
      base_addr = b;
      length    = (ADDR_W+1)'(len);
      start     = 1'b1;
      zeroStart = (len == 0);
      for (int p = 0; p < passes; p++) begin
         for (int i = 0; i < len; i++) begin
            a = b + ADDR_W'(i);
            e.data = memWord(a);
            e.last = (i == len - 1);
            e.fin  = (p == passes - 1);
            sbQ.push_back(e);
            addrQ.push_back(a);
         end
      end
      tick(1);
      start     = 1'b0;
      zeroStart = 1'b0;
   endtask

   task automatic waitDrained(input string tag, input int budget);
      int n = 0;
      while (sbQ.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      #1;
      checkOutput({tag, "_drained"}, 64'(sbQ.size() == 0), 64'd1);
   endtask

   initial begin
      int c0;
      int d0;
      int n;
      reset_n   = 1'b0;
      start     = 1'b0;
      loop      = 1'b0;
      stop      = 1'b0;
      base_addr = '0;
      length    = '0;
      out_ready = 1'b0;
      mem_readdata = '0;
      tick(2);

      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_done", 64'(done), 64'd0);
      checkOutput("rst_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_last", 64'(out_last), 64'd0);
      checkOutput("rst_cs", 64'(mem_chipselect), 64'd0);
      checkOutput("rst_addr", 64'(mem_address), 64'd0);
      checkOutput("tie_write", 64'(mem_write), 64'd0);
      checkOutput("tie_be", 64'(mem_byteenable), 64'hF);
      checkOutput("tie_clken", 64'(mem_clken), 64'd1);
      reset_n = 1'b1;
      tick(1);

      // Basic 4-word command: latency, back-to-back stream, start ignored on final handshake.
      $display("[TB] case: base 0x0010 length 4");
      out_ready = 1'b1;
      c0 = csCount;
      d0 = doneCount;
      applyStimulus(16'h0010, 4, 1);
      @(negedge clk);
      checkOutput("lat_c1_valid", 64'(out_valid), 64'd0);
      checkOutput("run_busy", 64'(busy), 64'd1);
      @(negedge clk);
      checkOutput("lat_c2_valid", 64'(out_valid), 64'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput($sformatf("stream_valid_%0d", i), 64'(out_valid), 64'd1);
         if (i == 2) begin
            @(posedge clk);
            #1;
            base_addr = 16'h0040;
            length    = 17'd3;
            start     = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      checkOutput("end_busy", 64'(busy), 64'd0);
      checkOutput("end_valid", 64'(out_valid), 64'd0);
      tick(3);
      checkOutput("t1_cs_count", 64'(csCount - c0), 64'd4);
      checkOutput("t1_done_count", 64'(doneCount - d0), 64'd1);

      // Address wrap at the top of the address space.
      $display("[TB] case: base 0xFFFE length 4");
      c0 = csCount;
      applyStimulus(16'hFFFE, 4, 1);
      waitDrained("t2", 50);
      tick(3);
      checkOutput("t2_cs_count", 64'(csCount - c0), 64'd4);
      checkOutput("t2_idle", 64'(busy), 64'd0);

      // 16 words under random backpressure, with a stray start while busy.
      $display("[TB] case: length 16 random out_ready");
      c0 = csCount;
      d0 = doneCount;
      applyStimulus(16'h0200, 16, 1);
      n = 0;
      while (sbQ.size() != 0 && n < 400) begin
         out_ready = 1'($urandom_range(0, 1));
         start     = (n == 5) || (n == 6);
         base_addr = 16'h0600;
         length    = 17'd7;
         tick(1);
         n++;
      end
      start     = 1'b0;
      out_ready = 1'b1;
      checkOutput("t3_drained", 64'(sbQ.size() == 0), 64'd1);
      tick(4);
      checkOutput("t3_cs_count", 64'(csCount - c0), 64'd16);
      checkOutput("t3_done_count", 64'(doneCount - d0), 64'd1);

      // Zero-length command.
      $display("[TB] case: length 0");
      c0 = csCount;
      d0 = doneCount;
      applyStimulus(16'h0300, 0, 1);
      @(negedge clk);
      checkOutput("t4_busy", 64'(busy), 64'd0);
      checkOutput("t4_done", 64'(done), 64'd1);
      tick(3);
      checkOutput("t4_busy_after", 64'(busy), 64'd0);
      checkOutput("t4_cs_count", 64'(csCount - c0), 64'd0);
      checkOutput("t4_done_count", 64'(doneCount - d0), 64'd1);

      // Reset in the middle of an 8-word command, then a clean restart.
      $display("[TB] case: reset mid-run");
      applyStimulus(16'h0400, 8, 1);
      tick(3);
      #3;
      reset_n = 1'b0;
      clearModel();
      #1;
      checkOutput("mr_busy", 64'(busy), 64'd0);
      checkOutput("mr_done", 64'(done), 64'd0);
      checkOutput("mr_valid", 64'(out_valid), 64'd0);
      checkOutput("mr_last", 64'(out_last), 64'd0);
      checkOutput("mr_cs", 64'(mem_chipselect), 64'd0);
      checkOutput("mr_addr", 64'(mem_address), 64'd0);
      tick(2);
      reset_n = 1'b1;
      tick(1);
      c0 = csCount;
      d0 = doneCount;
      applyStimulus(16'h0500, 3, 1);
      waitDrained("t5", 50);
      tick(3);
      checkOutput("t5_cs_count", 64'(csCount - c0), 64'd3);
      checkOutput("t5_done_count", 64'(doneCount - d0), 64'd1);

`ifdef ONCHIP_MEM_STREAMER_LOOP_EN
      // Repeat mode: stop raised during the second pass ends the command after it.
      $display("[TB] case: loop base 0x0100 length 2");
      c0 = csCount;
      d0 = doneCount;
      loop = 1'b1;
      applyStimulus(16'h0100, 2, 2);
      n = 0;
      while (csCount < c0 + 3 && n < 50) begin
         @(posedge clk);
         n++;
      end
      #1;
      checkOutput("t6_third_issue", 64'(csCount >= c0 + 3), 64'd1);
      stop = 1'b1;
      waitDrained("t6", 50);
      tick(4);
      loop = 1'b0;
      stop = 1'b0;
      checkOutput("t6_cs_count", 64'(csCount - c0), 64'd4);
      checkOutput("t6_done_count", 64'(doneCount - d0), 64'd1);
      checkOutput("t6_idle", 64'(busy), 64'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
